traffic_signal_timed_ctrl: RTL and testbench



---
 rtl/traffic_pkg.sv | 37 +++
 rtl/phase_timer.sv | 27 ++
 rtl/traffic_signal_timed_ctrl.sv | 139 +++++++++++++
 tb/tb_traffic_signal_timed_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - lamp encodings, state encodings and phase duration lookup
package traffic_pkg;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    typedef enum logic [2:0] {
        S0_HWY_GREEN       = 3'd0,
        S1_HWY_YELLOW      = 3'd1,
        S2_ALLRED_TO_CNTRY = 3'd2,
        S3_CNTRY_GREEN     = 3'd3,
        S4_CNTRY_YELLOW    = 3'd4,
        S5_ALLRED_TO_HWY   = 3'd5
    } state_t;

    // Length in cycles of the phase spent in state s; undefined encodings
    // fall back to the highway green, which is where they recover to.
    function automatic int unsigned phase_duration(
        input state_t      s,
        input int unsigned y2r,
        input int unsigned r2g,
        input int unsigned hwy_min,
        input int unsigned cntry_max
    );
        case (s)
            S0_HWY_GREEN:       return hwy_min;
            S1_HWY_YELLOW:      return y2r;
            S2_ALLRED_TO_CNTRY: return r2g;
            S3_CNTRY_GREEN:     return cntry_max;
            S4_CNTRY_YELLOW:    return y2r;
            S5_ALLRED_TO_HWY:   return r2g;
            default:            return hwy_min;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable saturating down-counter shared by all phases
module phase_timer #(
    parameter int              CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    // Load on phase entry, otherwise count down and hold at zero
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/traffic_signal_timed_ctrl.sv
// rtl/traffic_signal_timed_ctrl.sv - timed highway/country junction signal controller
module traffic_signal_timed_ctrl
    import traffic_pkg::*;
#(
    parameter int CNT_W           = 8,
    parameter int Y2R_DLY         = 3,
    parameter int R2G_DLY         = 2,
    parameter int HWY_MIN_GREEN   = 10,
    parameter int CNTRY_MAX_GREEN = 20
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       x,
    input  logic       emerg,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic [2:0] state_o
);

    // A duration of N is loaded as N-1, so N may reach 2^CNT_W
    localparam longint MAX_DUR = longint'(1) << CNT_W;

    if (Y2R_DLY < 1 || longint'(Y2R_DLY) > MAX_DUR) begin : g_bad_y2r
        $error("Y2R_DLY out of range");
    end
    if (R2G_DLY < 1 || longint'(R2G_DLY) > MAX_DUR) begin : g_bad_r2g
        $error("R2G_DLY out of range");
    end
    if (HWY_MIN_GREEN < 1 || longint'(HWY_MIN_GREEN) > MAX_DUR) begin : g_bad_hmin
        $error("HWY_MIN_GREEN out of range");
    end
    if (CNTRY_MAX_GREEN < 1 || longint'(CNTRY_MAX_GREEN) > MAX_DUR) begin : g_bad_cmax
        $error("CNTRY_MAX_GREEN out of range");
    end

    localparam logic [CNT_W-1:0] HMIN_RST = CNT_W'(HWY_MIN_GREEN - 1);

    state_t           state;
    state_t           state_next;
    logic             req;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic [CNT_W-1:0] tmr_cnt;
    logic             tmr_zero;
    logic [31:0]      next_dur;

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (HMIN_RST)
    ) u_timer (
        .clk      (clk),
        .clear    (clear),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

    // State register
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= S0_HWY_GREEN;
        end else begin
            state <= state_next;
        end
    end

    // Country request latch: remembers a car seen during highway green until yellow starts
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            req <= 1'b0;
        end else if (state == S0_HWY_GREEN) begin
            if (state_next == S1_HWY_YELLOW) begin
                req <= 1'b0;
            end else if (x) begin
                req <= 1'b1;
            end
        end
    end

    // Next-state logic; yellows and the all-red back to highway ignore emerg
    always_comb begin
        state_next = state;
        case (state)
            S0_HWY_GREEN: begin
                if (tmr_zero && (req || x) && !emerg) state_next = S1_HWY_YELLOW;
            end
            S1_HWY_YELLOW: begin
                if (tmr_zero) state_next = S2_ALLRED_TO_CNTRY;
            end
            S2_ALLRED_TO_CNTRY: begin
                if (emerg)         state_next = S0_HWY_GREEN;
                else if (tmr_zero) state_next = S3_CNTRY_GREEN;
            end
            S3_CNTRY_GREEN: begin
                if (emerg || !x || tmr_zero) state_next = S4_CNTRY_YELLOW;
            end
            S4_CNTRY_YELLOW: begin
                if (tmr_zero) state_next = S5_ALLRED_TO_HWY;
            end
            S5_ALLRED_TO_HWY: begin
                if (tmr_zero) state_next = S0_HWY_GREEN;
            end
            default: state_next = S0_HWY_GREEN;
        endcase
    end

    // Reload the shared timer with the new phase length on every state change
    always_comb begin
        next_dur     = phase_duration(state_next, Y2R_DLY, R2G_DLY,
                                      HWY_MIN_GREEN, CNTRY_MAX_GREEN);
        tmr_load     = (state_next != state);
        tmr_load_val = CNT_W'(next_dur - 32'd1);
    end

    // Lamp decode from the state register only
    always_comb begin
        hwy   = RED;
        cntry = RED;
        case (state)
            S0_HWY_GREEN:    hwy   = GREEN;
            S1_HWY_YELLOW:   hwy   = YELLOW;
            S3_CNTRY_GREEN:  cntry = GREEN;
            S4_CNTRY_YELLOW: cntry = YELLOW;
            default: begin
                hwy   = RED;
                cntry = RED;
            end
        endcase
    end

    assign state_o = state;

    // The timer never holds more than the remaining length of the current phase
    a_timer_in_phase: assert property (@(posedge clk) disable iff (clear)
        32'(tmr_cnt) < phase_duration(state, Y2R_DLY, R2G_DLY,
                                      HWY_MIN_GREEN, CNTRY_MAX_GREEN));

endmodule

// File: tb/tb_traffic_signal_timed_ctrl.sv
// tb/tb_traffic_signal_timed_ctrl.sv - randomized bench against a phase-age reference model
module tb_traffic_signal_timed_ctrl;

    localparam int CNT_W = 8;
    localparam int Y2R   = 3;
    localparam int R2G   = 2;
    localparam int HMIN  = 10;
    localparam int CMAX  = 20;

    logic       clk   = 1'b0;
    logic       clear = 1'b0;
    logic       x     = 1'b0;
    logic       emerg = 1'b0;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic [2:0] state_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int base   = 0;

    // model state: phase number, cycles spent in it (counting the current one), request flag
    int m_ph     = 0;
    int m_age    = 1;
    int m_nxt    = 0;
    bit m_req    = 1'b0;
    int edge_cnt = 0;

    always #5 clk = ~clk;

    traffic_signal_timed_ctrl #(
        .CNT_W           (CNT_W),
        .Y2R_DLY         (Y2R),
        .R2G_DLY         (R2G),
        .HWY_MIN_GREEN   (HMIN),
        .CNTRY_MAX_GREEN (CMAX)
    ) dut (
        .clk     (clk),
        .clear   (clear),
        .x       (x),
        .emerg   (emerg),
        .hwy     (hwy),
        .cntry   (cntry),
        .state_o (state_o)
    );

    function automatic int dur_of(input int ph);
        case (ph)
            0:       return HMIN;
            1:       return Y2R;
            2:       return R2G;
            3:       return CMAX;
            4:       return Y2R;
            default: return R2G;
        endcase
    endfunction

    function automatic int hwy_of(input int ph);
        return (ph == 0) ? 2 : (ph == 1) ? 1 : 0;
    endfunction

    function automatic int cntry_of(input int ph);
        return (ph == 3) ? 2 : (ph == 4) ? 1 : 0;
    endfunction

    // Reference: a phase ends once it has been occupied for its full length
    always @(posedge clk or posedge clear) begin
        if (clear) begin
            m_ph  = 0;
            m_age = 1;
            m_req = 1'b0;
        end else begin
            edge_cnt++;
            m_nxt = m_ph;
            case (m_ph)
                0: if (m_age >= HMIN && (m_req || x) && !emerg) m_nxt = 1;
                1: if (m_age >= Y2R) m_nxt = 2;
                2: if (emerg) m_nxt = 0; else if (m_age >= R2G) m_nxt = 3;
                3: if (emerg || !x || m_age >= CMAX) m_nxt = 4;
                4: if (m_age >= Y2R) m_nxt = 5;
                default: if (m_age >= R2G) m_nxt = 0;
            endcase
            if (m_ph == 0) begin
                if (m_nxt == 1) m_req = 1'b0;
                else if (x)     m_req = 1'b1;
            end
            if (m_nxt != m_ph) begin
                m_ph  = m_nxt;
                m_age = 1;
            end else if (m_age < 1000) begin
                m_age++;
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Advance one cycle and compare every output against the model
    task automatic cycle();
        @(negedge clk);
        if (!clear) begin
            chk("state_o", int'(state_o), m_ph);
            chk("hwy", int'(hwy), hwy_of(m_ph));
            chk("cntry", int'(cntry), cntry_of(m_ph));
            chk("one_road_open", int'(hwy != 2'b00 && cntry != 2'b00), 0);
            chk("phase_len", int'(m_age <= dur_of(m_ph) || m_ph == 0), 1);
        end
    endtask

    task automatic run_to(input int e);
        while (edge_cnt - base < e) cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hwy"}, int'(hwy), 2);
        chk({tag, "_cntry"}, int'(cntry), 0);
        chk({tag, "_state"}, int'(state_o), 0);
    endtask

    // Assert clear between edges, check the immediate effect, keep it held
    task automatic mid_clear(input string tag);
        #2;
        clear = 1'b1;
        #1;
        check_reset_outputs(tag);
    endtask

    task automatic release_clear();
        cycle();
        clear = 1'b0;
        base  = edge_cnt;
    endtask

    initial begin
        #1;
        clear = 1'b1;
        #1;
        check_reset_outputs("por");
        x = 1'b1;
        release_clear();

        // x held from release: S0 10, S1 3, S2 2, then full 20-cycle country green
        run_to(9);  chk("a_s0_end", int'(state_o), 0);
        run_to(10); chk("a_s1", int'(state_o), 1);
        run_to(14); chk("a_s2", int'(state_o), 2);
        run_to(15); chk("a_cgreen", int'(cntry), 2);
        run_to(34); chk("a_s3_last", int'(state_o), 3);
        run_to(35); chk("a_s4", int'(state_o), 4);
        run_to(38); chk("a_s5", int'(state_o), 5);
        run_to(40); chk("a_back_hwy", int'(hwy), 2);

        // clear in the middle of country green, then no cars
        run_to(60); chk("b_in_s3", int'(state_o), 3);
        mid_clear("b_clr");
        x = 1'b0;
        release_clear();
        run_to(30); chk("b_idle_s0", int'(state_o), 0);

        // x drops after five cycles of country green
        mid_clear("c_clr");
        x = 1'b1;
        release_clear();
        run_to(19); chk("c_s3", int'(state_o), 3);
        x = 1'b0;
        run_to(20); chk("c_s4", int'(state_o), 4);
        run_to(23); chk("c_s5", int'(state_o), 5);
        run_to(25); chk("c_s0", int'(state_o), 0);

        // single-cycle x pulse is latched until yellow
        mid_clear("d_clr");
        x = 1'b0;
        release_clear();
        run_to(3);
        x = 1'b1;
        run_to(4);
        x = 1'b0;
        run_to(9);  chk("d_req_held", int'(dut.req), 1);
        chk("d_still_s0", int'(state_o), 0);
        run_to(10); chk("d_s1", int'(state_o), 1);
        chk("d_req_cleared", int'(dut.req), 0);

        // emergency: stay in S0 with a car, yellow completes, S2 aborts, S3 cut short
        mid_clear("e_clr");
        x = 1'b1;
        emerg = 1'b1;
        release_clear();
        run_to(20); chk("e_s0_hold", int'(state_o), 0);
        x = 1'b0;
        emerg = 1'b0;
        run_to(21); chk("e_req_served", int'(state_o), 1);
        run_to(22);
        emerg = 1'b1;
        run_to(23); chk("e_yellow_kept", int'(state_o), 1);
        run_to(24); chk("e_s2", int'(state_o), 2);
        run_to(25); chk("e_s2_abort", int'(state_o), 0);
        emerg = 1'b0;
        x = 1'b1;
        run_to(41); chk("e_s3", int'(state_o), 3);
        emerg = 1'b1;
        run_to(42); chk("e_s3_cut", int'(state_o), 4);
        emerg = 1'b0;

        // randomized traffic with occasional emergencies and asynchronous clears
        for (int blk = 0; blk < 60; blk++) begin
            int p;
            p = $urandom_range(0, 100);
            for (int i = 0; i < 50; i++) begin
                x     = ($urandom_range(0, 99) < p);
                emerg = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 299) == 0) begin
                    mid_clear("r_clr");
                    #1;
                    clear = 1'b0;
                end
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
